// File: rtl/axi_addr_router.sv
// Single-master, two-slave AXI4 address router with an internal DECERR responder.
// Optional error logging (err_valid/err_addr/err_clr) is enabled by defining XBAR_ERRLOG_EN.
//
// state  | meaning
// IDLE   | no transaction owned; arbitrate AR vs AW and decode the granted address
// RD     | read routed to slave sel_q until the last R beat is accepted
// WR     | write routed to slave sel_q until the B response is accepted
// RD_ERR | unmapped read: accept AR, return arlen+1 DECERR beats
// WR_ERR | unmapped write: accept AW, sink W up to wlast, return one DECERR B
module axi_addr_router #(
  parameter logic [31:0] S0_BASE = 32'h8000_0000,
  parameter logic [31:0] S0_MASK = 32'hF800_0000,
  parameter logic [31:0] S1_BASE = 32'h1000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef XBAR_ERRLOG_EN
  input  logic        err_clr,
  output logic        err_valid,
  output logic [31:0] err_addr,
`endif
  input  logic [31:0] M_araddr,
  input  logic [3:0]  M_arid,
  input  logic [7:0]  M_arlen,
  input  logic [2:0]  M_arsize,
  input  logic [1:0]  M_arburst,
  input  logic        M_arvalid,
  output logic        M_arready,
  output logic [31:0] M_rdata,
  output logic [1:0]  M_rresp,
  output logic [3:0]  M_rid,
  output logic        M_rlast,
  output logic        M_rvalid,
  input  logic        M_rready,
  input  logic [31:0] M_awaddr,
  input  logic [3:0]  M_awid,
  input  logic [7:0]  M_awlen,
  input  logic [2:0]  M_awsize,
  input  logic [1:0]  M_awburst,
  input  logic        M_awvalid,
  output logic        M_awready,
  input  logic [31:0] M_wdata,
  input  logic [3:0]  M_wstrb,
  input  logic        M_wlast,
  input  logic        M_wvalid,
  output logic        M_wready,
  output logic [1:0]  M_bresp,
  output logic [3:0]  M_bid,
  output logic        M_bvalid,
  input  logic        M_bready,
  output logic [31:0] S0_araddr,
  output logic [3:0]  S0_arid,
  output logic [7:0]  S0_arlen,
  output logic [2:0]  S0_arsize,
  output logic [1:0]  S0_arburst,
  output logic        S0_arvalid,
  input  logic        S0_arready,
  input  logic [31:0] S0_rdata,
  input  logic [1:0]  S0_rresp,
  input  logic [3:0]  S0_rid,
  input  logic        S0_rlast,
  input  logic        S0_rvalid,
  output logic        S0_rready,
  output logic [31:0] S0_awaddr,
  output logic [3:0]  S0_awid,
  output logic [7:0]  S0_awlen,
  output logic [2:0]  S0_awsize,
  output logic [1:0]  S0_awburst,
  output logic        S0_awvalid,
  input  logic        S0_awready,
  output logic [31:0] S0_wdata,
  output logic [3:0]  S0_wstrb,
  output logic        S0_wlast,
  output logic        S0_wvalid,
  input  logic        S0_wready,
  input  logic [1:0]  S0_bresp,
  input  logic [3:0]  S0_bid,
  input  logic        S0_bvalid,
  output logic        S0_bready,
  output logic [31:0] S1_araddr,
  output logic [3:0]  S1_arid,
  output logic [7:0]  S1_arlen,
  output logic [2:0]  S1_arsize,
  output logic [1:0]  S1_arburst,
  output logic        S1_arvalid,
  input  logic        S1_arready,
  input  logic [31:0] S1_rdata,
  input  logic [1:0]  S1_rresp,
  input  logic [3:0]  S1_rid,
  input  logic        S1_rlast,
  input  logic        S1_rvalid,
  output logic        S1_rready,
  output logic [31:0] S1_awaddr,
  output logic [3:0]  S1_awid,
  output logic [7:0]  S1_awlen,
  output logic [2:0]  S1_awsize,
  output logic [1:0]  S1_awburst,
  output logic        S1_awvalid,
  input  logic        S1_awready,
  output logic [31:0] S1_wdata,
  output logic [3:0]  S1_wstrb,
  output logic        S1_wlast,
  output logic        S1_wvalid,
  input  logic        S1_wready,
  input  logic [1:0]  S1_bresp,
  input  logic [3:0]  S1_bid,
  input  logic        S1_bvalid,
  output logic        S1_bready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    RD_ERR = 3'd3,
    WR_ERR = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_wr_q, last_wr_d;
  logic        hs_q, hs_d;
  logic        wdone_q, wdone_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;

  logic rd_s0, rd_s1, wr_s0, wr_s1, rd_hit, wr_hit;
  logic rd_gnt, wr_gnt;
  logic ar_hs, aw_hs, w_last_hs, r_hs, r_done, b_done;

  assign rd_s0  = (M_araddr & S0_MASK) == S0_BASE;
  assign rd_s1  = (M_araddr & S1_MASK) == S1_BASE;
  assign wr_s0  = (M_awaddr & S0_MASK) == S0_BASE;
  assign wr_s1  = (M_awaddr & S1_MASK) == S1_BASE;
  assign rd_hit = rd_s0 | rd_s1;
  assign wr_hit = wr_s0 | wr_s1;

  // last_wr_q high means the write side wins the next AR/AW tie
  assign rd_gnt = (state_q == IDLE) & M_arvalid & (~M_awvalid | ~last_wr_q);
  assign wr_gnt = (state_q == IDLE) & M_awvalid & (~M_arvalid | last_wr_q);

  assign ar_hs     = M_arvalid & M_arready;
  assign aw_hs     = M_awvalid & M_awready;
  assign w_last_hs = M_wvalid & M_wready & M_wlast;
  assign r_hs      = M_rvalid & M_rready;
  assign r_done    = r_hs & M_rlast;
  assign b_done    = M_bvalid & M_bready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rd_gnt) begin
          state_d = rd_hit ? RD : RD_ERR;
        end else if (wr_gnt) begin
          state_d = wr_hit ? WR : WR_ERR;
        end
      end
      RD, RD_ERR: if (r_done) state_d = IDLE;
      WR, WR_ERR: if (b_done) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Selected-slave return path
  logic        s_arready, s_rlast, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_rid, s_bid;

  assign s_arready = sel_q ? S1_arready : S0_arready;
  assign s_rdata   = sel_q ? S1_rdata   : S0_rdata;
  assign s_rresp   = sel_q ? S1_rresp   : S0_rresp;
  assign s_rid     = sel_q ? S1_rid     : S0_rid;
  assign s_rlast   = sel_q ? S1_rlast   : S0_rlast;
  assign s_rvalid  = sel_q ? S1_rvalid  : S0_rvalid;
  assign s_awready = sel_q ? S1_awready : S0_awready;
  assign s_wready  = sel_q ? S1_wready  : S0_wready;
  assign s_bresp   = sel_q ? S1_bresp   : S0_bresp;
  assign s_bid     = sel_q ? S1_bid     : S0_bid;
  assign s_bvalid  = sel_q ? S1_bvalid  : S0_bvalid;

  always_comb begin
    M_arready = 1'b0;
    M_rdata   = '0;
    M_rresp   = '0;
    M_rid     = '0;
    M_rlast   = 1'b0;
    M_rvalid  = 1'b0;
    M_awready = 1'b0;
    M_wready  = 1'b0;
    M_bresp   = '0;
    M_bid     = '0;
    M_bvalid  = 1'b0;
    case (state_q)
      RD: begin
        M_arready = s_arready & ~hs_q;
        M_rdata   = s_rdata;
        M_rresp   = s_rresp;
        M_rid     = s_rid;
        M_rlast   = s_rlast;
        M_rvalid  = s_rvalid;
      end
      WR: begin
        M_awready = s_awready & ~hs_q;
        M_wready  = s_wready & ~wdone_q;
        M_bresp   = s_bresp;
        M_bid     = s_bid;
        M_bvalid  = s_bvalid;
      end
      RD_ERR: begin
        M_arready = ~hs_q;
        M_rvalid  = hs_q;
        M_rresp   = 2'b11;
        M_rid     = id_q;
        M_rlast   = hs_q & (cnt_q == len_q);
      end
      WR_ERR: begin
        M_awready = ~hs_q;
        M_wready  = ~wdone_q;
        M_bvalid  = hs_q & wdone_q;
        M_bresp   = 2'b11;
        M_bid     = id_q;
      end
      default: ;
    endcase
  end

  // Forward path; address/last-W gating keeps a slave from seeing a second transaction
  logic rd0, rd1, wr0, wr1;
  assign rd0 = (state_q == RD) & ~sel_q;
  assign rd1 = (state_q == RD) &  sel_q;
  assign wr0 = (state_q == WR) & ~sel_q;
  assign wr1 = (state_q == WR) &  sel_q;

  assign S0_araddr  = rd0 ? M_araddr  : '0;
  assign S0_arid    = rd0 ? M_arid    : '0;
  assign S0_arlen   = rd0 ? M_arlen   : '0;
  assign S0_arsize  = rd0 ? M_arsize  : '0;
  assign S0_arburst = rd0 ? M_arburst : '0;
  assign S0_arvalid = rd0 & ~hs_q & M_arvalid;
  assign S0_rready  = rd0 & M_rready;
  assign S0_awaddr  = wr0 ? M_awaddr  : '0;
  assign S0_awid    = wr0 ? M_awid    : '0;
  assign S0_awlen   = wr0 ? M_awlen   : '0;
  assign S0_awsize  = wr0 ? M_awsize  : '0;
  assign S0_awburst = wr0 ? M_awburst : '0;
  assign S0_awvalid = wr0 & ~hs_q & M_awvalid;
  assign S0_wdata   = wr0 ? M_wdata   : '0;
  assign S0_wstrb   = wr0 ? M_wstrb   : '0;
  assign S0_wlast   = wr0 & M_wlast;
  assign S0_wvalid  = wr0 & ~wdone_q & M_wvalid;
  assign S0_bready  = wr0 & M_bready;

  assign S1_araddr  = rd1 ? M_araddr  : '0;
  assign S1_arid    = rd1 ? M_arid    : '0;
  assign S1_arlen   = rd1 ? M_arlen   : '0;
  assign S1_arsize  = rd1 ? M_arsize  : '0;
  assign S1_arburst = rd1 ? M_arburst : '0;
  assign S1_arvalid = rd1 & ~hs_q & M_arvalid;
  assign S1_rready  = rd1 & M_rready;
  assign S1_awaddr  = wr1 ? M_awaddr  : '0;
  assign S1_awid    = wr1 ? M_awid    : '0;
  assign S1_awlen   = wr1 ? M_awlen   : '0;
  assign S1_awsize  = wr1 ? M_awsize  : '0;
  assign S1_awburst = wr1 ? M_awburst : '0;
  assign S1_awvalid = wr1 & ~hs_q & M_awvalid;
  assign S1_wdata   = wr1 ? M_wdata   : '0;
  assign S1_wstrb   = wr1 ? M_wstrb   : '0;
  assign S1_wlast   = wr1 & M_wlast;
  assign S1_wvalid  = wr1 & ~wdone_q & M_wvalid;
  assign S1_bready  = wr1 & M_bready;

  always_comb begin
    sel_d     = sel_q;
    last_wr_d = last_wr_q;
    hs_d      = hs_q;
    wdone_d   = wdone_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    len_d     = len_q;
    if (state_q == IDLE) begin
      hs_d    = 1'b0;
      wdone_d = 1'b0;
      cnt_d   = '0;
      if (rd_gnt) begin
        sel_d     = ~rd_s0 & rd_s1;
        last_wr_d = 1'b1;
        id_d      = M_arid;
        len_d     = M_arlen;
      end else if (wr_gnt) begin
        sel_d     = ~wr_s0 & wr_s1;
        last_wr_d = 1'b0;
        id_d      = M_awid;
        len_d     = M_awlen;
      end
    end else begin
      if (ar_hs || aw_hs) hs_d = 1'b1;
      if (w_last_hs) wdone_d = 1'b1;
      if (state_q == RD_ERR && r_hs) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q     <= 1'b0;
      last_wr_q <= 1'b0;
      hs_q      <= 1'b0;
      wdone_q   <= 1'b0;
      cnt_q     <= '0;
      id_q      <= '0;
      len_q     <= '0;
    end else begin
      sel_q     <= sel_d;
      last_wr_q <= last_wr_d;
      hs_q      <= hs_d;
      wdone_q   <= wdone_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      len_q     <= len_d;
    end
  end

`ifdef XBAR_ERRLOG_EN
  logic        err_valid_q, err_valid_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic        err_entry;

  assign err_entry = (rd_gnt & ~rd_hit) | (wr_gnt & ~wr_hit);

  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (err_entry) begin
      err_valid_d = 1'b1;
      err_addr_d  = rd_gnt ? M_araddr : M_awaddr;
    end else if (err_clr) begin
      err_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_valid = err_valid_q;
  assign err_addr  = err_addr_q;
`endif

endmodule
